// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan stage.
package seg7_pkg;
  typedef enum logic {BLANK, DISP} state_e;

  // Active-low glyphs, bit order g..a, indexed by nibble value.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;
endpackage

// File: rtl/seg7_scan_mux_if.sv
// Register-side value/controls and display pins of the scan stage.
interface seg7_scan_mux_if;
  logic [15:0] VALUE_IN;
  logic [3:0]  DOT_IN;
  logic        LZB_EN;
  logic [7:0]  HEX_OUT;
  logic [3:0]  SEG_SELECT;
  logic        FRAME_TICK;

  modport master (output VALUE_IN, DOT_IN, LZB_EN, input HEX_OUT, SEG_SELECT, FRAME_TICK);
  modport slave  (input VALUE_IN, DOT_IN, LZB_EN, output HEX_OUT, SEG_SELECT, FRAME_TICK);
endinterface

// File: rtl/hex_to_seg7.sv
// Nibble to active-low cathodes; blank forces segments off but keeps the DP.
module hex_to_seg7 import seg7_pkg::*; (
  input  logic [3:0] nibble,
  input  logic       dot,
  input  logic       blank,
  output logic [7:0] seg
);
  assign seg = {~dot, blank ? 7'h7F : GLYPH[nibble]};
endmodule

// File: rtl/seg7_scan_mux.sv
// Refresh-timed digit scanner with ghost blanking, leading-zero suppression
// and a per-frame input snapshot so a mid-frame write never tears.
module seg7_scan_mux import seg7_pkg::*; #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 20
) (
  input  logic           CLK,
  input  logic           RESET,
  seg7_scan_mux_if.slave bus
);
  localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_e           state, nxt_state;
  logic [1:0]       idx, nxt_idx;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [15:0]      snap_v, nxt_v;
  logic [3:0]       snap_d, nxt_d;
  logic             snap_l, nxt_l;
  logic             snap_take;
  logic             lzb_hide;
  logic [7:0]       seg;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt + 1'b1;
    snap_take = 1'b0;
    if (state == DISP) begin
      if (cnt == DISP_LAST) begin
        nxt_cnt = '0;
        if (BLANK_CYCLES == 0) begin
          nxt_idx   = idx + 1'b1;
          snap_take = (idx == 2'd3);
        end else begin
          nxt_state = BLANK;
        end
      end
    end else if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
      nxt_cnt   = '0;
      nxt_state = DISP;
      nxt_idx   = idx + 1'b1;
      snap_take = (idx == 2'd3);
    end
    nxt_v = snap_take ? bus.VALUE_IN : snap_v;
    nxt_d = snap_take ? bus.DOT_IN   : snap_d;
    nxt_l = snap_take ? bus.LZB_EN   : snap_l;
  end

  // Decode the digit about to be shown so pins move on the same edge as the state.
  assign lzb_hide = nxt_l && (nxt_idx != 2'd0) && ((nxt_v >> {nxt_idx, 2'b00}) == 16'h0);

  hex_to_seg7 u_dec (
    .nibble (nxt_v[{nxt_idx, 2'b00} +: 4]),
    .dot    (nxt_d[nxt_idx]),
    .blank  (lzb_hide),
    .seg    (seg)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= BLANK;
      idx            <= 2'd3;
      cnt            <= '0;
      snap_v         <= '0;
      snap_d         <= '0;
      snap_l         <= 1'b0;
      bus.HEX_OUT    <= SEG_OFF;
      bus.SEG_SELECT <= AN_OFF;
      bus.FRAME_TICK <= 1'b0;
    end else begin
      state          <= nxt_state;
      idx            <= nxt_idx;
      cnt            <= nxt_cnt;
      snap_v         <= nxt_v;
      snap_d         <= nxt_d;
      snap_l         <= nxt_l;
      bus.HEX_OUT    <= (nxt_state == DISP) ? seg : SEG_OFF;
      bus.SEG_SELECT <= (nxt_state == DISP) ? ~(4'b0001 << nxt_idx) : AN_OFF;
      bus.FRAME_TICK <= snap_take;
    end
  end
endmodule
